// File: rtl/row_req_ctrl.sv
`default_nettype none
// ============================================================================
// row_req_ctrl: latches per-row events as pending requests, presents them to
// a priority arbiter, and hands each granted row address to a ready/valid sink.
// Rev 1.0
// ============================================================================
module row_req_ctrl #(
  parameter int ROWS   = 16,
  parameter int ADDR_W = $clog2(ROWS),
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [ROWS-1:0]   event_i,
  output logic [ROWS-1:0]   req_o,
  input  logic [ROWS-1:0]   gnt_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CNT_W-1:0]  drop_cnt_o,
  output logic              gnt_err_o
);

  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ROWS-1:0]     pend_q, pend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    drop_q, drop_d;

  logic                w_gnt_any;
  logic                w_gnt_onehot;
  logic                w_gnt_legal;
  logic [ADDR_W-1:0]   w_gnt_idx;
  logic [ROWS-1:0]     w_clr;
  logic [ROWS-1:0]     w_drops;
  logic [SUM_W-1:0]    w_drop_sum;

  always_comb begin
    w_gnt_any    = (gnt_i != '0);
    w_gnt_onehot = w_gnt_any && ((gnt_i & (gnt_i - ROWS'(1))) == '0);
    w_gnt_legal  = w_gnt_onehot && ((gnt_i & ~pend_q) == '0);

    // OR-encode is exact for a one-hot grant; illegal grants never use it.
    w_gnt_idx = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (gnt_i[i]) begin
        w_gnt_idx = w_gnt_idx | ADDR_W'(i);
      end
    end

    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    err_d   = err_q;
    w_clr   = '0;

    case (state_q)
      IDLE: begin
        if (w_gnt_legal) begin
          w_clr   = gnt_i;
          addr_d  = w_gnt_idx;
          valid_d = 1'b1;
          state_d = SEND;
        end else if (w_gnt_any) begin
          err_d = 1'b1;
        end
      end
      SEND: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A row re-armed in the cycle it is granted keeps the new event and is not a drop.
    w_drops = event_i & pend_q & ~w_clr;
    pend_d  = (pend_q & ~w_clr) | event_i;

    w_drop_sum = {1'b0, drop_q};
    for (int i = 0; i < ROWS; i++) begin
      w_drop_sum = w_drop_sum + SUM_W'(w_drops[i]);
    end
    drop_d = w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign req_o      = (reset_i && state_q == IDLE) ? pend_q : '0;
  assign addr_o     = addr_q;
  assign valid_o    = valid_q;
  assign drop_cnt_o = drop_q;
  assign gnt_err_o  = err_q;

endmodule
`default_nettype wire
